// File: rtl/tm1637_pkg.sv
`default_nettype none
// ============================================================================
// tm1637_pkg : shared states, TM1637 command bytes and retry limit
// Rev 1.0
// ============================================================================
package tm1637_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_C1_ISSUE  = 3'd1,
    ST_C1_WAIT   = 3'd2,
    ST_C2_ISSUE  = 3'd3,
    ST_C2_WAIT   = 3'd4,
    ST_C3_ISSUE  = 3'd5,
    ST_C3_WAIT   = 3'd6,
    ST_FRAME_END = 3'd7
  } state_t;

  localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
  localparam logic [7:0] CMD_ADDR0        = 8'hC0;
  localparam logic [7:0] CMD_DISP_BASE    = 8'h80;
  localparam int         MAX_RETRIES      = 2;

  function automatic logic is_issue(state_t s);
    return (s == ST_C1_ISSUE) || (s == ST_C2_ISSUE) || (s == ST_C3_ISSUE);
  endfunction

  function automatic logic is_wait(state_t s);
    return (s == ST_C1_WAIT) || (s == ST_C2_WAIT) || (s == ST_C3_WAIT);
  endfunction

  function automatic logic [7:0] disp_ctrl(logic on, logic [2:0] br);
    return CMD_DISP_BASE | {4'b0000, on, br};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tm1637_frame_sequencer_seg7_hex_encode.sv
`default_nettype none
// ============================================================================
// seg7_hex_encode : hex nibble to gfedcba segment byte, bit7 = decimal point
// Rev 1.0
// ============================================================================
module seg7_hex_encode (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [6:0] pattern;

  always_comb begin
    pattern = 7'h00;
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      4'hF: pattern = 7'h71;
      default: pattern = 7'h00;
    endcase
  end

  assign seg = {dp, pattern};

endmodule
`default_nettype wire

// File: rtl/tm1637_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tm1637_frame_sequencer : runs data-cmd / addr+segments / display-ctrl frames
// through i2c_simple_master. Optional macro: TM_SEQ_RETRY_EN.   Rev 1.0
// ============================================================================
module tm1637_frame_sequencer
  import tm1637_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  input  logic        update,
  output logic        m_start,
  output logic [7:0]  m_data_array [0:7],
  output logic [2:0]  m_num_bytes,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_ack_error,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] REF_LAST = 32'(REFRESH_CYCLES - 1);

  state_t      state_q, state_d;
  logic        issue_ph_q;
  logic        done_seen_q;
  logic        nack_q;
  logic        pending_q;
  logic [31:0] tmo_cnt_q;
  logic [31:0] ref_cnt_q;
  logic [15:0] snap_digits;
  logic [3:0]  snap_dp;
  logic [2:0]  snap_br;
  logic        snap_on;
  logic [7:0]  seg [0:3];

  logic frame_start, attempt_fail, set_err, refresh_expire, load_cmd;
  logic wait_finish, wait_nack, wait_timeout;
`ifdef TM_SEQ_RETRY_EN
  logic [2:0] attempt_q;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_enc
    seg7_hex_encode u_enc (
      .nibble (snap_digits[4*i +: 4]),
      .dp     (snap_dp[i]),
      .seg    (seg[i])
    );
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_FRAME_END);
  assign load_cmd   = is_issue(state_d) && !is_issue(state_q);

  assign refresh_expire = (REFRESH_CYCLES != 0) && (state_q == ST_IDLE) &&
                          !pending_q && (ref_cnt_q == REF_LAST);

  always_comb begin
    state_d      = state_q;
    m_start      = 1'b0;
    frame_start  = 1'b0;
    attempt_fail = 1'b0;
    set_err      = 1'b0;
    // Leave WAIT only once the master is idle again so the next start edge is seen.
    wait_finish  = (done_seen_q | m_done) & ~m_busy;
    wait_nack    = nack_q | (m_done & m_ack_error);
    wait_timeout = (tmo_cnt_q == TMO_LAST);
    case (state_q)
      ST_IDLE: begin
        if (pending_q && !m_busy) begin
          state_d     = ST_C1_ISSUE;
          frame_start = 1'b1;
        end
      end
      ST_C1_ISSUE, ST_C2_ISSUE, ST_C3_ISSUE: begin
        if (issue_ph_q) begin
          m_start = 1'b1;
          state_d = state_t'(state_q + 3'd1);
        end
      end
      ST_C1_WAIT, ST_C2_WAIT, ST_C3_WAIT: begin
        if (wait_finish) begin
          if (wait_nack)                  attempt_fail = 1'b1;
          else if (state_q == ST_C1_WAIT) state_d = ST_C2_ISSUE;
          else if (state_q == ST_C2_WAIT) state_d = ST_C3_ISSUE;
          else                            state_d = ST_FRAME_END;
        end else if (wait_timeout) begin
          attempt_fail = 1'b1;
        end
      end
      ST_FRAME_END: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (attempt_fail) begin
`ifdef TM_SEQ_RETRY_EN
      if (attempt_q < 3'(MAX_RETRIES)) begin
        state_d = ST_C1_ISSUE;
      end else begin
        state_d = ST_FRAME_END;
        set_err = 1'b1;
      end
`else
      state_d = ST_FRAME_END;
      set_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_ph_q  <= 1'b0;
      done_seen_q <= 1'b0;
      nack_q      <= 1'b0;
      pending_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_br     <= '0;
      snap_on     <= 1'b0;
      err         <= 1'b0;
      m_num_bytes <= '0;
      for (int i = 0; i < 8; i++) m_data_array[i] <= 8'h00;
`ifdef TM_SEQ_RETRY_EN
      attempt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      // Each ISSUE state spends one cycle with data settled before m_start.
      issue_ph_q <= is_issue(state_q) & ~issue_ph_q;
      pending_q  <= (pending_q & ~frame_start) | update | refresh_expire;

      if (is_wait(state_q)) begin
        tmo_cnt_q   <= tmo_cnt_q + 32'd1;
        done_seen_q <= done_seen_q | m_done;
        nack_q      <= nack_q | (m_done & m_ack_error);
      end else begin
        tmo_cnt_q   <= '0;
        done_seen_q <= 1'b0;
        nack_q      <= 1'b0;
      end

      if (state_q == ST_FRAME_END || refresh_expire)
        ref_cnt_q <= '0;
      else if (state_q == ST_IDLE && !pending_q && REFRESH_CYCLES != 0)
        ref_cnt_q <= ref_cnt_q + 32'd1;

      if (frame_start) begin
        snap_digits <= digits;
        snap_dp     <= dp_mask;
        snap_br     <= brightness;
        snap_on     <= display_on;
        err         <= 1'b0;
`ifdef TM_SEQ_RETRY_EN
        attempt_q   <= '0;
`endif
      end else if (set_err) begin
        err <= 1'b1;
      end

`ifdef TM_SEQ_RETRY_EN
      if (attempt_fail && !set_err) attempt_q <= attempt_q + 3'd1;
`endif

      if (load_cmd) begin
        for (int i = 0; i < 8; i++) m_data_array[i] <= 8'h00;
        case (state_d)
          ST_C1_ISSUE: begin
            m_data_array[0] <= CMD_DATA_AUTOINC;
            m_num_bytes     <= 3'd1;
          end
          ST_C2_ISSUE: begin
            m_data_array[0] <= CMD_ADDR0;
            m_data_array[1] <= seg[0];
            m_data_array[2] <= seg[1];
            m_data_array[3] <= seg[2];
            m_data_array[4] <= seg[3];
            m_num_bytes     <= 3'd5;
          end
          default: begin
            m_data_array[0] <= disp_ctrl(snap_on, snap_br);
            m_num_bytes     <= 3'd1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tm1637_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tm1637_frame_sequencer : randomized frames against a transaction-list model
// Rev 1.0
// ============================================================================
module tb_tm1637_frame_sequencer;
  localparam int TMO     = 500;
  localparam int REF     = 1000;
  localparam int RETRIES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [2:0]  brightness;
  logic        display_on, update;
  logic        m_start, m_busy, m_done, m_ack_error;
  logic [7:0]  m_data_array [0:7];
  logic [2:0]  m_num_bytes;
  logic        busy, frame_done, err;

  logic [15:0] r_digits = 16'h1234;
  logic [3:0]  r_dp = 4'h0;
  logic [2:0]  r_br = 3'd3;
  logic        r_on = 1'b1, r_update = 1'b0, r_ack_error = 1'b0;
  logic        r_m_start, r_m_busy, r_m_done, r_busy, r_frame_done, r_err;
  logic [7:0]  r_data_array [0:7];
  logic [2:0]  r_num_bytes;

  always #5 clk = ~clk;

  tm1637_frame_sequencer #(.REFRESH_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .brightness(brightness), .display_on(display_on), .update(update),
    .m_start(m_start), .m_data_array(m_data_array), .m_num_bytes(m_num_bytes),
    .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error),
    .busy(busy), .frame_done(frame_done), .err(err));

  tm1637_frame_sequencer #(.REFRESH_CYCLES(REF), .TIMEOUT_CYCLES(TMO)) dut_r (
    .clk(clk), .rst_n(rst_n), .digits(r_digits), .dp_mask(r_dp),
    .brightness(r_br), .display_on(r_on), .update(r_update),
    .m_start(r_m_start), .m_data_array(r_data_array), .m_num_bytes(r_num_bytes),
    .m_busy(r_m_busy), .m_done(r_m_done), .m_ack_error(r_ack_error),
    .busy(r_busy), .frame_done(r_frame_done), .err(r_err));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: frame -> list of master transactions
  logic [6:0]  seg_tbl [16];
  logic [66:0] exp_q [$];
  logic [66:0] cap_q [$];

  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
    return {dp, seg_tbl[n]};
  endfunction

  function automatic logic [66:0] tx(input logic [2:0] num, input logic [7:0] b0,
                                     input logic [7:0] b1, input logic [7:0] b2,
                                     input logic [7:0] b3, input logic [7:0] b4);
    return {num, b0, b1, b2, b3, b4, 24'h0};
  endfunction

  task automatic model_frame(input logic [15:0] d, input logic [3:0] dp, input logic [2:0] br,
                             input logic on, input int nacks, output logic exp_err);
    int tries_left;
`ifdef TM_SEQ_RETRY_EN
    tries_left = RETRIES;
`else
    tries_left = 0;
`endif
    exp_err = 1'b0;
    while (1) begin
      exp_q.push_back(tx(3'd1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00));
      exp_q.push_back(tx(3'd5, 8'hC0, seg_of(d[3:0], dp[0]), seg_of(d[7:4], dp[1]),
                         seg_of(d[11:8], dp[2]), seg_of(d[15:12], dp[3])));
      if (nacks > 0) begin
        nacks--;
        if (tries_left > 0) begin
          tries_left--;
          continue;
        end
        exp_err = 1'b1;
        break;
      end
      exp_q.push_back(tx(3'd1, 8'h80 | (8'(on) << 3) | 8'(br), 8'h00, 8'h00, 8'h00, 8'h00));
      break;
    end
  endtask

  // ---------------- master responder and monitor for dut
  int   cyc = 0;
  int   mst_cnt, nack_c2_left, frames_seen, starts_seen, start_cyc, done_cyc;
  bit   mst_act, mst_nack, mst_tail, stuck_all, stuck_c2, post_chk, done_prev;
  logic err_at_done;
  logic [66:0] cur, prev_cur, held;

  always @(posedge clk) cyc++;

  initial begin
    frames_seen = 0; starts_seen = 0; nack_c2_left = 0;
    stuck_all = 0; stuck_c2 = 0; err_at_done = 1'b0;
  end

  always @(negedge clk) begin
    cur = {m_num_bytes, 64'h0};
    for (int i = 0; i < 8; i++) cur[63-8*i -: 8] = m_data_array[i];
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_ack_error = 0;
      mst_act = 0; mst_tail = 0; post_chk = 0; done_prev = 0;
    end else begin
      if (post_chk) check("arr_post_start", cur, held);
      post_chk = 0;
      if (done_prev) check("busy_after_done", {79'b0, busy}, 80'd0);
      done_prev = frame_done;
      m_done = 0; m_ack_error = 0;
      if (mst_tail) begin m_busy = 0; mst_tail = 0; end
      if (mst_act) begin
        if (mst_cnt == 0) begin
          m_done = 1; m_ack_error = mst_nack; mst_act = 0;
          if ($urandom_range(0, 1) == 1) mst_tail = 1; else m_busy = 0;
        end else mst_cnt--;
      end
      if (frame_done) begin frames_seen++; err_at_done = err; done_cyc = cyc; end
      if (m_start) begin
        starts_seen++;
        start_cyc = cyc;
        check("arr_pre_start", prev_cur, cur);
        held = cur; post_chk = 1;
        if (!m_busy) begin
          cap_q.push_back(cur);
          m_busy = 1;
          if (!(stuck_all || (stuck_c2 && m_data_array[0] == 8'hC0))) begin
            mst_act  = 1;
            mst_cnt  = $urandom_range(1, 6);
            mst_nack = (m_data_array[0] == 8'hC0) && (nack_c2_left > 0);
            if (mst_nack) nack_c2_left--;
          end
        end
      end
    end
    prev_cur = cur;
  end

  // ---------------- always-acknowledging master for the auto-refresh instance
  int r_cnt, r_last_done, r_gaps;
  initial r_gaps = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_m_busy = 0; r_m_done = 0; r_cnt = 0; r_last_done = -1;
    end else begin
      r_m_done = 0;
      if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0) begin r_m_done = 1; r_m_busy = 0; end
      end
      if (r_m_start && !r_m_busy) begin
        // frame_done, 1000 idle cycles to expiry, start decision, issue setup, start
        if (r_data_array[0] == 8'h40 && r_last_done >= 0) begin
          check("refresh_gap", 80'(cyc - r_last_done), 80'(REF + 3));
          r_gaps++;
          r_last_done = -1;
        end
        r_m_busy = 1; r_cnt = 3;
      end
      if (r_frame_done) begin
        r_last_done = cyc;
        check("refresh_err", {79'b0, r_err}, 80'd0);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic pulse_update();
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check("busy_rise", {79'b0, busy}, 80'd1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin @(negedge clk); n++; end
    check("frame_wait", 80'(frames_seen >= target), 80'd1);
  endtask

  task automatic compare_txs(input string tag);
    check({tag, "_ntx"}, 80'(cap_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 80'(cap_q[i]), 80'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [15:0] d, input logic [3:0] dp,
                           input logic [2:0] br, input logic on, input int nacks,
                           input bit scramble);
    logic e;
    int   f0;
    digits = d; dp_mask = dp; brightness = br; display_on = on;
    nack_c2_left = nacks;
    model_frame(d, dp, br, on, nacks, e);
    f0 = frames_seen;
    pulse_update();
    if (scramble) begin
      wait_busy();
      digits = 16'($urandom); dp_mask = 4'($urandom);
      brightness = 3'($urandom); display_on = 1'($urandom);
    end
    wait_frames(f0 + 1, 4000);
    repeat (3) @(negedge clk);
    check({tag, "_frames"}, 80'(frames_seen), 80'(f0 + 1));
    check({tag, "_err"}, {79'b0, err_at_done}, {79'b0, e});
    check({tag, "_err_sticky"}, {79'b0, err}, {79'b0, e});
    compare_txs(tag);
    nack_c2_left = 0;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_busy"},  {79'b0, busy},       80'd0);
    check({tag, "_start"}, {79'b0, m_start},    80'd0);
    check({tag, "_err"},   {79'b0, err},        80'd0);
    check({tag, "_done"},  {79'b0, frame_done}, 80'd0);
    check({tag, "_num"},   80'(m_num_bytes),    80'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stuck_all = 0; stuck_c2 = 0; nack_c2_left = 0;
    cap_q.delete(); exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence
  initial begin
    logic [79:0] v;
    logic        e;
    int          f0, s0, sel, nk;
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    digits = 16'h0; dp_mask = 4'h0; brightness = 3'd0; display_on = 1'b0; update = 1'b0;

    repeat (3) @(negedge clk);
    v = '0;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = m_data_array[i];
    check("rst_arr",   v, 80'd0);
    check("rst_num",   80'(m_num_bytes), 80'd0);
    check("rst_busy",  {79'b0, busy}, 80'd0);
    check("rst_start", {79'b0, m_start}, 80'd0);
    check("rst_done",  {79'b0, frame_done}, 80'd0);
    check("rst_err",   {79'b0, err}, 80'd0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_frame", 80'(starts_seen), 80'd0);

    run_frame("f4321", 16'h4321, 4'b0000, 3'd7, 1'b1, 0, 1'b0);
    run_frame("fFEDC", 16'hFEDC, 4'b0101, 3'd2, 1'b1, 0, 1'b0);
    run_frame("nack_all", 16'hA5C3, 4'b1000, 3'd4, 1'b0, RETRIES + 1, 1'b0);
    run_frame("nack_once", 16'h0789, 4'b0010, 3'd1, 1'b1, 1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      sel = $urandom_range(0, 5);
      nk  = (sel == 4) ? 1 : (sel == 5) ? RETRIES + 1 : 0;
      run_frame($sformatf("rnd%0d", k), 16'($urandom), 4'($urandom), 3'($urandom),
                1'($urandom), nk, 1'b1);
    end

    // Several updates inside one frame collapse into a single follow-up frame.
    f0 = frames_seen;
    digits = 16'h1357; dp_mask = 4'h1; brightness = 3'd5; display_on = 1'b1;
    model_frame(16'h1357, 4'h1, 3'd5, 1'b1, 0, e);
    pulse_update();
    wait_busy();
    for (int k = 0; k < 3; k++) begin
      digits = 16'($urandom); dp_mask = 4'($urandom);
      brightness = 3'($urandom); display_on = 1'($urandom);
      pulse_update();
    end
    model_frame(digits, dp_mask, brightness, display_on, 0, e);
    wait_frames(f0 + 2, 8000);
    repeat (50) @(negedge clk);
    check("coal_frames", 80'(frames_seen), 80'(f0 + 2));
    compare_txs("coal");

    // Master accepts C1 and then never finishes.
    stuck_all = 1;
    f0 = frames_seen;
    s0 = starts_seen;
    digits = 16'h2222;
    model_frame(16'h2222, 4'h0, 3'd0, 1'b0, 0, e);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    pulse_update();
    wait_frames(f0 + 1, 3000);
    repeat (2) @(negedge clk);
    check("tmo_err", {79'b0, err_at_done}, 80'd1);
    check("tmo_err_sticky", {79'b0, err}, 80'd1);
`ifdef TM_SEQ_RETRY_EN
    check("tmo_starts", 80'(starts_seen - s0), 80'(RETRIES + 1));
`else
    check("tmo_starts", 80'(starts_seen - s0), 80'd1);
    check("tmo_gap", 80'(done_cyc - start_cyc), 80'(TMO + 1));
`endif
    compare_txs("tmo");
    async_reset("rst_tmo");

    // Reset while the sequencer sits in C2_WAIT.
    stuck_c2 = 1;
    digits = 16'h9999;
    pulse_update();
    s0 = 0;
    while (cap_q.size() < 2 && s0 < 100) begin @(negedge clk); s0++; end
    check("c2_reached", 80'(cap_q.size()), 80'd2);
    repeat (10) @(negedge clk);
    async_reset("rst_c2");
    repeat (3) @(negedge clk);
    run_frame("post_rst", 16'hB0D1, 4'b0110, 3'd6, 1'b1, 0, 1'b0);

    s0 = 0;
    while (r_gaps < 3 && s0 < 6000) begin @(negedge clk); s0++; end
    check("refresh_count", 80'(r_gaps >= 3), 80'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
